// File: rtl/mem_hammer_ctrl_if.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | mem_hammer_ctrl_if                                                  |
// | Request/read-return bus between the hammer controller and the       |
// | memory-port adapter.                                                |
// | Rev 1.0                                                             |
// +---------------------------------------------------------------------+
interface mem_hammer_ctrl_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int WORD_WIDTH = 64
);
    logic                  mem_valid;
    logic                  mem_ready;
    logic                  mem_write;
    logic [ADDR_WIDTH-1:0] gen_address;
    logic [WORD_WIDTH-1:0] gen_word;
    logic                  rd_valid;
    logic [WORD_WIDTH-1:0] rd_data;

    modport master (
        output mem_valid, mem_write, gen_address, gen_word,
        input  mem_ready, rd_valid, rd_data
    );

    modport slave (
        input  mem_valid, mem_write, gen_address, gen_word,
        output mem_ready, rd_valid, rd_data
    );
endinterface
`default_nettype wire

// File: rtl/mem_hammer_ctrl.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | mem_hammer_ctrl                                                     |
// | Multi-aggressor Rowhammer controller: init victim/aggressors,       |
// | hammer, read back and tally bit flips. Optional first-flip capture  |
// | enabled by MEM_HAMMER_FIRST_FLIP_EN.                                |
// | Rev 1.0                                                             |
// +---------------------------------------------------------------------+
module mem_hammer_ctrl #(
    parameter int ADDR_WIDTH  = 64,
    parameter int WORD_WIDTH  = 64,
    parameter int ROW_WIDTH   = 12,
    parameter int ROW_POS     = 10,
    parameter int COL_WIDTH   = 10,
    parameter int COL_POS     = 1,
    parameter int MAX_AGGR    = 4,
    parameter int TALLY_LANES = 4
) (
    input  wire logic                         clk,
    input  wire logic                         reset_n,
    input  wire logic                         start,
    input  wire logic [WORD_WIDTH-1:0]        pattern,
    input  wire logic [ADDR_WIDTH-1:0]        address,
    input  wire logic [31:0]                  count,
    input  wire logic [1:0]                   mode,
    input  wire logic [$clog2(MAX_AGGR+1)-1:0] num_aggr,
    mem_hammer_ctrl_if.master                 mem,
    output logic                              busy,
    output logic                              done,
    output logic [3:0]                        state,
    output logic [63:0]                       flip_total,
    output logic [63:0]                       flip_1to0,
    output logic [COL_WIDTH-1:0]              first_flip_col,
    output logic                              first_flip_valid
);
    localparam int c_na_w    = $clog2(MAX_AGGR+1);
    localparam int c_lane_w  = WORD_WIDTH / TALLY_LANES;
    localparam int c_lane_iw = (TALLY_LANES > 1) ? $clog2(TALLY_LANES) : 1;

    typedef enum logic [3:0] {
        S_IDLE        = 4'd0,
        S_INIT_VICTIM = 4'd1,
        S_INIT_AGGR   = 4'd2,
        S_HAMMER      = 4'd3,
        S_READ_REQ    = 4'd4,
        S_READ_WAIT   = 4'd5,
        S_TALLY       = 4'd6,
        S_DONE        = 4'd7
    } state_t;

    state_t                r_state;
    logic                  r_busy, r_done;
    logic [WORD_WIDTH-1:0] r_pattern, r_rd;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_count, r_hcnt;
    logic [c_na_w-1:0]     r_aggr_cnt, r_aggr_idx;
    logic [COL_WIDTH-1:0]  r_col;
    logic [c_lane_iw-1:0]  r_lane;
    logic [63:0]           r_flip_total, r_flip_1to0;
    logic                  r_mem_valid, r_mem_write;
    logic [ADDR_WIDTH-1:0] r_gen_address;
    logic [WORD_WIDTH-1:0] r_gen_word;

    logic                  w_xfer, w_start_ok, w_idx_last;
    logic [c_na_w-1:0]     w_aggr_cnt, w_idx_next, w_idx_wrap;
    logic [ROW_WIDTH-1:0]  w_victim_row;
    logic [WORD_WIDTH-1:0] w_xor, w_loss;
    logic [c_lane_w-1:0]   w_xor_lanes  [TALLY_LANES];
    logic [c_lane_w-1:0]   w_loss_lanes [TALLY_LANES];
    logic [63:0]           w_pc_total, w_pc_loss;

    function automatic logic [ADDR_WIDTH-1:0] f_addr(input logic [ADDR_WIDTH-1:0] base,
                                                     input logic [ROW_WIDTH-1:0]  row,
                                                     input logic [COL_WIDTH-1:0]  col);
        logic [ADDR_WIDTH-1:0] a;
        a = base;
        a[ROW_POS +: ROW_WIDTH] = row;
        a[COL_POS +: COL_WIDTH] = col;
        return a;
    endfunction

    // Offset magnitude 2*(i>>1)+1 is just i with its LSB forced high.
    function automatic logic [ROW_WIDTH-1:0] f_aggr_row(input logic [ROW_WIDTH-1:0] victim,
                                                        input logic [c_na_w-1:0]    idx);
        logic [ROW_WIDTH-1:0] mag;
        mag = ROW_WIDTH'({idx[c_na_w-1:1], 1'b1});
        return idx[0] ? victim - mag : victim + mag;
    endfunction

    function automatic logic [63:0] f_sat_add(input logic [63:0] a, input logic [63:0] b);
        logic [64:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[64] ? '1 : s[63:0];
    endfunction

    always_comb begin
        w_aggr_cnt = c_na_w'(2);
        case (mode)
            2'd0: w_aggr_cnt = c_na_w'(1);
            2'd2: begin
                if (num_aggr < c_na_w'(2))
                    w_aggr_cnt = c_na_w'(2);
                else if (num_aggr > c_na_w'(MAX_AGGR))
                    w_aggr_cnt = c_na_w'(MAX_AGGR);
                else
                    w_aggr_cnt = num_aggr;
                w_aggr_cnt[0] = 1'b0;
            end
            default: ;
        endcase
    end

    assign w_xfer       = r_mem_valid & mem.mem_ready;
    assign w_start_ok   = start & ((r_state == S_IDLE) | (r_state == S_DONE));
    assign w_victim_row = r_addr[ROW_POS +: ROW_WIDTH];
    assign w_idx_next   = r_aggr_idx + 1'b1;
    assign w_idx_last   = (w_idx_next == r_aggr_cnt);
    assign w_idx_wrap   = w_idx_last ? '0 : w_idx_next;
    assign w_xor        = r_pattern ^ r_rd;
    assign w_loss       = r_pattern & ~r_rd;

    generate
        for (genvar g = 0; g < TALLY_LANES; g++) begin : g_lane
            assign w_xor_lanes[g]  = w_xor[g*c_lane_w +: c_lane_w];
            assign w_loss_lanes[g] = w_loss[g*c_lane_w +: c_lane_w];
        end
    endgenerate

    assign w_pc_total = 64'($countones(w_xor_lanes[r_lane]));
    assign w_pc_loss  = 64'($countones(w_loss_lanes[r_lane]));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_pattern     <= '0;
            r_rd          <= '0;
            r_addr        <= '0;
            r_count       <= '0;
            r_hcnt        <= '0;
            r_aggr_cnt    <= '0;
            r_aggr_idx    <= '0;
            r_col         <= '0;
            r_lane        <= '0;
            r_flip_total  <= '0;
            r_flip_1to0   <= '0;
            r_mem_valid   <= 1'b0;
            r_mem_write   <= 1'b0;
            r_gen_address <= '0;
            r_gen_word    <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_pattern     <= pattern;
                        r_addr        <= address;
                        r_count       <= count;
                        r_aggr_cnt    <= w_aggr_cnt;
                        r_aggr_idx    <= '0;
                        r_hcnt        <= '0;
                        r_col         <= '0;
                        r_flip_total  <= '0;
                        r_flip_1to0   <= '0;
                        r_busy        <= 1'b1;
                        r_done        <= 1'b0;
                        r_mem_valid   <= 1'b1;
                        r_mem_write   <= 1'b1;
                        r_gen_address <= f_addr(address, address[ROW_POS +: ROW_WIDTH], '0);
                        r_gen_word    <= pattern;
                        r_state       <= S_INIT_VICTIM;
                    end
                end
                S_INIT_VICTIM: begin
                    if (w_xfer) begin
                        if (r_col == '1) begin
                            r_col         <= '0;
                            r_aggr_idx    <= '0;
                            r_gen_address <= f_addr(r_addr, f_aggr_row(w_victim_row, '0), '0);
                            r_gen_word    <= ~r_pattern;
                            r_state       <= S_INIT_AGGR;
                        end else begin
                            r_col         <= r_col + 1'b1;
                            r_gen_address <= f_addr(r_addr, w_victim_row, r_col + 1'b1);
                        end
                    end
                end
                S_INIT_AGGR: begin
                    if (w_xfer) begin
                        if (r_col != '1) begin
                            r_col         <= r_col + 1'b1;
                            r_gen_address <= f_addr(r_addr, f_aggr_row(w_victim_row, r_aggr_idx),
                                                    r_col + 1'b1);
                        end else if (!w_idx_last) begin
                            r_col         <= '0;
                            r_aggr_idx    <= w_idx_next;
                            r_gen_address <= f_addr(r_addr, f_aggr_row(w_victim_row, w_idx_next), '0);
                        end else begin
                            r_col       <= '0;
                            r_aggr_idx  <= '0;
                            r_hcnt      <= '0;
                            r_mem_write <= 1'b0;
                            if (r_count == 32'd0) begin
                                r_gen_address <= f_addr(r_addr, w_victim_row, '0);
                                r_state       <= S_READ_REQ;
                            end else begin
                                r_gen_address <= f_addr(r_addr, f_aggr_row(w_victim_row, '0), '0);
                                r_state       <= S_HAMMER;
                            end
                        end
                    end
                end
                S_HAMMER: begin
                    if (w_xfer) begin
                        r_hcnt <= r_hcnt + 32'd1;
                        if (r_hcnt + 32'd1 == r_count) begin
                            r_gen_address <= f_addr(r_addr, w_victim_row, '0);
                            r_state       <= S_READ_REQ;
                        end else begin
                            r_aggr_idx    <= w_idx_wrap;
                            r_gen_address <= f_addr(r_addr, f_aggr_row(w_victim_row, w_idx_wrap), '0);
                        end
                    end
                end
                S_READ_REQ: begin
                    // A read return coincident with acceptance belongs to an earlier hammer read.
                    if (w_xfer) begin
                        r_mem_valid <= 1'b0;
                        r_state     <= S_READ_WAIT;
                    end
                end
                S_READ_WAIT: begin
                    if (mem.rd_valid) begin
                        r_rd    <= mem.rd_data;
                        r_lane  <= '0;
                        r_state <= S_TALLY;
                    end
                end
                S_TALLY: begin
                    r_flip_total <= f_sat_add(r_flip_total, w_pc_total);
                    r_flip_1to0  <= f_sat_add(r_flip_1to0, w_pc_loss);
                    if (r_lane == c_lane_iw'(TALLY_LANES-1)) begin
                        if (r_col == '1) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_col         <= r_col + 1'b1;
                            r_mem_valid   <= 1'b1;
                            r_gen_address <= f_addr(r_addr, w_victim_row, r_col + 1'b1);
                            r_state       <= S_READ_REQ;
                        end
                    end else begin
                        r_lane <= r_lane + 1'b1;
                    end
                end
                default: begin
                    r_mem_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_done      <= 1'b1;
                    r_state     <= S_DONE;
                end
            endcase
        end
    end

`ifdef MEM_HAMMER_FIRST_FLIP_EN
    logic [COL_WIDTH-1:0] r_ff_col;
    logic                 r_ff_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ff_col   <= '0;
            r_ff_valid <= 1'b0;
        end else if (w_start_ok) begin
            r_ff_col   <= '0;
            r_ff_valid <= 1'b0;
        end else if ((r_state == S_TALLY) && !r_ff_valid && (|w_xor_lanes[r_lane])) begin
            r_ff_col   <= r_col;
            r_ff_valid <= 1'b1;
        end
    end

    assign first_flip_col   = r_ff_col;
    assign first_flip_valid = r_ff_valid;
`else
    assign first_flip_col   = '0;
    assign first_flip_valid = 1'b0;
`endif

    assign mem.mem_valid   = r_mem_valid;
    assign mem.mem_write   = r_mem_write;
    assign mem.gen_address = r_gen_address;
    assign mem.gen_word    = r_gen_word;
    assign busy            = r_busy;
    assign done            = r_done;
    assign state           = r_state;
    assign flip_total      = r_flip_total;
    assign flip_1to0       = r_flip_1to0;
endmodule
`default_nettype wire

// File: tb/tb_mem_hammer_ctrl.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | tb_mem_hammer_ctrl                                                  |
// | Scoreboard bench: expected request stream queued per test, popped   |
// | as the DUT transfers. Rev 1.0                                       |
// +---------------------------------------------------------------------+
module tb_mem_hammer_ctrl;
    localparam logic [63:0] c_base  = 64'hA5A5_0000_0000_03FF;
    localparam logic [63:0] c_fmask = (64'hFFF << 10) | (64'h3 << 1);

    typedef struct packed {
        logic        wr;
        logic [63:0] addr;
        logic [63:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [63:0] pattern = '0;
    logic [63:0] address = '0;
    logic [31:0] count = '0;
    logic [1:0]  mode = '0;
    logic [2:0]  num_aggr = '0;
    logic        busy, done, first_flip_valid;
    logic [3:0]  state;
    logic [63:0] flip_total, flip_1to0;
    logic [1:0]  first_flip_col;

    mem_hammer_ctrl_if #(.ADDR_WIDTH(64), .WORD_WIDTH(64)) mem_bus ();

    mem_hammer_ctrl #(
        .ADDR_WIDTH(64), .WORD_WIDTH(64), .ROW_WIDTH(12), .ROW_POS(10),
        .COL_WIDTH(2), .COL_POS(1), .MAX_AGGR(4), .TALLY_LANES(4)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .pattern(pattern),
        .address(address), .count(count), .mode(mode), .num_aggr(num_aggr),
        .mem(mem_bus.master), .busy(busy), .done(done), .state(state),
        .flip_total(flip_total), .flip_1to0(flip_1to0),
        .first_flip_col(first_flip_col), .first_flip_valid(first_flip_valid)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass = 0;
    exp_t        sb_q[$];
    exp_t        mon_e;
    int          h_cnt = 0;
    logic        rv_pend = 1'b0;
    logic [63:0] rv_data = '0;
    logic        stall_prev = 1'b0;
    logic [63:0] stall_addr = '0;
    logic [3:0]  prev_state = '0;
    logic [3:0]  after_aggr = '0;
    logic [63:0] cur_pat = '0;
    logic [1:0]  flip_col = '0;
    logic [63:0] flip_mask = '0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [63:0] exp_addr(input int row, input int col);
        return (c_base & ~c_fmask) | (64'(row & 'hFFF) << 10) | (64'(col) << 1);
    endfunction

    function automatic int aggr_row(input int vrow, input int i);
        int off;
        off = 2 * (i / 2) + 1;
        if (i % 2 == 1) off = -off;
        return (vrow + off) & 'hFFF;
    endfunction

    function automatic int eff_aggr(input logic [1:0] md, input int na);
        int n;
        if (md == 2'd0) return 1;
        if (md != 2'd2) return 2;
        n = (na < 2) ? 2 : (na > 4) ? 4 : na;
        return n - (n % 2);
    endfunction

    task automatic build_expect(input logic [63:0] pat, input int vrow, input logic [1:0] md,
                                input int na, input int cnt);
        int a;
        a = eff_aggr(md, na);
        for (int c = 0; c < 4; c++) sb_q.push_back('{1'b1, exp_addr(vrow, c), pat});
        for (int i = 0; i < a; i++)
            for (int c = 0; c < 4; c++)
                sb_q.push_back('{1'b1, exp_addr(aggr_row(vrow, i), c), ~pat});
        for (int h = 0; h < cnt; h++) sb_q.push_back('{1'b0, exp_addr(aggr_row(vrow, h % a), 0), 64'h0});
        for (int c = 0; c < 4; c++) sb_q.push_back('{1'b0, exp_addr(vrow, c), 64'h0});
    endtask

    // Monitor + memory model: transfers are decided by values settled at the falling edge.
    always @(negedge clk) begin
        rv_pend = 1'b0;
        if (reset_n) begin
            if (stall_prev) begin
                check_val("stall_valid", 64'(mem_bus.mem_valid), 64'd1);
                check_val("stall_addr", mem_bus.gen_address, stall_addr);
            end
            stall_prev = mem_bus.mem_valid && !mem_bus.mem_ready;
            stall_addr = mem_bus.gen_address;
            if (prev_state == 4'd2 && state != 4'd2) after_aggr = state;
            prev_state = state;
            if (mem_bus.mem_valid && mem_bus.mem_ready) begin
                if (!mem_bus.mem_write) begin
                    rv_pend = 1'b1;
                    rv_data = cur_pat ^ ((mem_bus.gen_address[2:1] == flip_col) ? flip_mask : 64'h0);
                    if (state == 4'd3) h_cnt++;
                end
                if (sb_q.size() == 0) begin
                    check_val("sb_extra", 64'd1, 64'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check_val("sb_wr", 64'(mem_bus.mem_write), 64'(mon_e.wr));
                    check_val("sb_addr", mem_bus.gen_address, mon_e.addr);
                    if (mon_e.wr) check_val("sb_data", mem_bus.gen_word, mon_e.data);
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        mem_bus.rd_valid = rv_pend;
        mem_bus.rd_data  = rv_data;
    end

    task automatic launch(input logic [63:0] pat, input int vrow, input logic [1:0] md,
                          input int na, input int cnt, input logic [1:0] fcol, input logic [63:0] fmask);
        build_expect(pat, vrow, md, na, cnt);
        cur_pat = pat; flip_col = fcol; flip_mask = fmask;
        h_cnt = 0; after_aggr = '0;
        @(posedge clk); #1;
        pattern = pat; address = c_base | (64'(vrow) << 10); mode = md;
        num_aggr = 3'(na); count = 32'(cnt); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_val("valid_after_start", 64'(mem_bus.mem_valid), 64'd1);
        check_val("busy_after_start", 64'(busy), 64'd1);
        // Inputs are latched; scrambling them now must not matter.
        pattern = ~pat; address = '0; count = 32'(cnt + 7);
    endtask

    task automatic run_test(input logic [63:0] pat, input int vrow, input logic [1:0] md,
                            input int na, input int cnt, input logic [1:0] fcol,
                            input logic [63:0] fmask, input bit bp);
        int cyc;
        int hb;
        bit bp_done;
        launch(pat, vrow, md, na, cnt, fcol, fmask);
        cyc = 0; bp_done = 0;
        while (!done && cyc < 3000) begin
            start = (cyc == 20);
            if (bp && !bp_done && state == 4'd3 && h_cnt >= 3) begin
                hb = h_cnt;
                mem_bus.mem_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                check_val("bp_hold_count", 64'(h_cnt), 64'(hb));
                mem_bus.mem_ready = 1'b1;
                bp_done = 1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        check_val("done", 64'(done), 64'd1);
        check_val("state_done", 64'(state), 64'd7);
        check_val("busy_done", 64'(busy), 64'd0);
        check_val("flip_total", flip_total, 64'($countones(fmask)));
        check_val("flip_1to0", flip_1to0, 64'($countones(pat & fmask)));
        check_val("sb_left", 64'(sb_q.size()), 64'd0);
        check_val("hammer_cnt", 64'(h_cnt), 64'(cnt));
        check_val("after_aggr", 64'(after_aggr), (cnt == 0) ? 64'd4 : 64'd3);
`ifdef MEM_HAMMER_FIRST_FLIP_EN
        check_val("ff_valid", 64'(first_flip_valid), 64'(fmask != 64'h0));
        if (fmask != 64'h0) check_val("ff_col", 64'(first_flip_col), 64'(fcol));
`else
        check_val("ff_valid", 64'(first_flip_valid), 64'd0);
        check_val("ff_col", 64'(first_flip_col), 64'd0);
`endif
        sb_q.delete();
    endtask

    initial begin
        int cyc;
        mem_bus.mem_ready = 1'b1;
        mem_bus.rd_valid  = 1'b0;
        mem_bus.rd_data   = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_state", 64'(state), 64'd0);
        check_val("rst_valid", 64'(mem_bus.mem_valid), 64'd0);
        check_val("rst_word", mem_bus.gen_word, 64'd0);
        check_val("rst_total", flip_total, 64'd0);
        check_val("rst_done", 64'(done), 64'd0);
        check_val("rst_busy", 64'(busy), 64'd0);
        reset_n = 1'b1;

        run_test(64'h0123_4567_89AB_CDEF, 'h010, 2'd1, 0, 6, 2'd0, 64'h0, 0);
        run_test('1, 'h020, 2'd0, 0, 3, 2'd2, 64'h20, 0);
        run_test(64'h5555_AAAA_5555_AAAA, 'h7A0, 2'd1, 0, 0, 2'd0, 64'h0, 0);
        run_test(64'h00FF_00FF_F0F0_0F0F, 'h000, 2'd2, 4, 5, 2'd1, 64'h8000_0000_0001_0001, 0);
        run_test(64'hDEAD_BEEF_0BAD_F00D, 'hFFF, 2'd2, 3, 10, 2'd3, 64'h0000_0001_0000_0000, 1);
        run_test(64'hC3C3_3C3C_1234_8765, 'h400, 2'd2, 7, 9, 2'd0, 64'hFFFF_0000_0000_0000, 0);
        run_test(64'h0F0F_0F0F_0F0F_0F0F, 'h123, 2'd3, 1, 4, 2'd1, 64'h0000_0000_00F0_0000, 0);

        // Reset in the middle of hammering.
        launch(64'h1111_2222_3333_4444, 'h050, 2'd1, 0, 50, 2'd0, 64'h0);
        cyc = 0;
        while (state != 4'd3 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_val("reach_hammer", 64'(state), 64'd3);
        repeat (2) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check_val("mid_rst_state", 64'(state), 64'd0);
        check_val("mid_rst_valid", 64'(mem_bus.mem_valid), 64'd0);
        check_val("mid_rst_total", flip_total, 64'd0);
        check_val("mid_rst_word", mem_bus.gen_word, 64'd0);
        check_val("mid_rst_busy", 64'(busy), 64'd0);
        sb_q.delete();
        repeat (3) @(posedge clk);
        #1;
        check_val("in_rst_valid", 64'(mem_bus.mem_valid), 64'd0);
        reset_n = 1'b1;
        run_test(64'h0123_4567_89AB_CDEF, 'h010, 2'd1, 0, 6, 2'd3, 64'hF000_0000_0000_000F, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mem_hammer_ctrl.md
# mem_hammer_ctrl

Parametrised multi-aggressor Rowhammer test controller. It initialises a victim row with `pattern` and every aggressor row with `~pattern`, then issues `count` hammer reads that rotate across the aggressor rows. It then reads the victim row back and tallies 0→1 and 1→0 bit flips. It sits between the register block (configuration and results) and the memory-port adapter, using a valid/ready request handshake.

## Interface
- `ADDR_WIDTH`, 64: address width.
- `WORD_WIDTH`, 64: data word width.
- `ROW_WIDTH`, 12 / `ROW_POS`, 10: row field width and LSB position in the address.
- `COL_WIDTH`, 10 / `COL_POS`, 1: column field width and LSB position.
- `MAX_AGGR`, 4: maximum aggressor rows (even, ≥2).
- `TALLY_LANES`, 4: slices per word compared one per cycle; must divide `WORD_WIDTH`.

Ports:
- `clk` in 1: single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle launch pulse; honoured only in IDLE or DONE.
- `pattern` in WORD_WIDTH: victim data. Aggressors receive `~pattern`.
- `address` in ADDR_WIDTH: victim row base. Column bits are ignored.
- `count` in 32: total hammer reads.
- `mode` in 2: 0 single-sided, 1 double-sided, 2 many-sided, 3 treated as 1.
- `num_aggr` in $clog2(MAX_AGGR+1): aggressor count for mode 2.
- `mem_valid` out 1: request valid.
- `mem_ready` in 1: request accepted.
- `mem_write` out 1: 1 = write, 0 = read.
- `gen_address` out ADDR_WIDTH: request address.
- `gen_word` out WORD_WIDTH: write data.
- `rd_valid` in 1 / `rd_data` in WORD_WIDTH: read return.
- `busy` out 1; `done` out 1; `state` out 4.
- `flip_total` out 64; `flip_1to0` out 64: flip counters.
- `first_flip_col` out COL_WIDTH; `first_flip_valid` out 1: see Configuration.

## Operation
- States:
  - IDLE=0
  - INIT_VICTIM=1
  - INIT_AGGR=2
  - HAMMER=3
  - READ_REQ=4
  - READ_WAIT=5
  - TALLY=6
  - DONE=7
  - Any other code → DONE.
- Aggressor index i maps to row offset +(2·(i>>1)+1) for even i and −(2·(i>>1)+1) for odd i. The sequence is +1, −1, +3, −3, …
- Effective aggressor count A:
  - mode 0: A=1.
  - mode 1 or 3: A=2.
  - mode 2: `num_aggr` clamped to [2, MAX_AGGR], then rounded down to even.
- Row arithmetic wraps modulo 2^ROW_WIDTH. Non-row, non-column address bits come from `address`.
- Inputs are latched at `start`. Later changes to them have no effect until the next start.
- Counters clear at `start`.
- INIT_VICTIM: writes `pattern` to columns 0..2^COL_WIDTH−1 of the victim row, then → INIT_AGGR.
- INIT_AGGR: writes `~pattern` to every column of each aggressor row in index order, then → HAMMER.
- HAMMER: issues `count` reads at column 0. Aggressor index advances per accepted read, wrapping at A. If `count`==0, go directly to READ_REQ. `rd_valid` is ignored in this state.
- READ_REQ: issues one read of the current victim column, then → READ_WAIT.
- READ_WAIT: on `rd_valid`, captures `rd_data` → TALLY. Only one read is outstanding.
- TALLY: spends TALLY_LANES cycles. Lane k does:
  - `flip_total` += popcount((pattern^rd)[k]).
  - `flip_1to0` += popcount((pattern&~rd)[k]).
  - Both counters saturate at all-ones.
  - After the last lane: if column = max → DONE, else column+1 → READ_REQ.
- DONE: `done`=1 and counters hold. `start` restarts the sequence.
- `busy` = state ∉ {IDLE, DONE}. `start` while busy is ignored.

## Timing
- Reset (asynchronous, immediate):
  - state=IDLE.
  - All outputs 0, including counters and `gen_word`.
  - Reset mid-operation abandons any pending request. No further `mem_valid` is issued.
- `mem_valid`, `mem_write`, `gen_address` and `gen_word` are registered. `mem_valid` rises the cycle after `start`.
- A transfer occurs on a cycle with `mem_valid` & `mem_ready`.
- While `mem_valid`=1 and `mem_ready`=0, request outputs are held stable.
- Back-to-back transfers are sustained at one per cycle in the INIT and HAMMER states.
- `mem_valid` is 0 in READ_WAIT, TALLY, IDLE and DONE.
- `rd_valid` arriving in the same cycle the READ_REQ transfer is accepted is ignored. The returned data must arrive in a later cycle.
- Counters update one cycle after the corresponding TALLY lane cycle. Final values are stable when `done` rises.

## Configuration
- `MEM_HAMMER_FIRST_FLIP_EN` defined:
  - The first TALLY lane with a nonzero XOR latches `first_flip_col` and sets `first_flip_valid`.
  - Both hold until the next `start` or reset.
- Undefined: `first_flip_col`=0 and `first_flip_valid`=0 permanently. No capture logic is built.

## Test plan
- Double-sided, no flips (COL_WIDTH=2, victim row 0x010, mode 1, count 6, `mem_ready`=1, `rd_data`=`pattern`): expect 4 victim writes, then 8 aggressor writes to rows 0x011 and 0x00F. Hammer rows are 0x011, 0x00F ×3. Final `flip_total`=0 and `done`=1.
- Single flip (`pattern`=all-ones, column 2 returns bit 5 = 0): expect `flip_total`=1, `flip_1to0`=1. With the macro defined, also expect `first_flip_col`=2 and `first_flip_valid`=1.
- Row wrap (victim row 0, mode 2, `num_aggr`=4): aggressor rows are 0x001, 0xFFF, 0x003, 0xFFD.
- Backpressure: hold `mem_ready` low for 5 cycles mid-HAMMER. `gen_address` stays stable and the hammer count does not advance. The total hammer-read count still equals `count`.
- `count`=0: HAMMER transfers nothing, and READ_REQ follows INIT_AGGR directly.
- Reset mid-HAMMER: dropping `reset_n` immediately gives state=0, `mem_valid`=0 and counters 0. A new `start` runs the full sequence cleanly.
